// File: rtl/cfg_bank_programmer_if.sv
// Bitstream stream plus bl/wl tile bus for cfg_bank_programmer.
// Optional checksum signal is present only when CFG_CHECKSUM_EN is defined.
interface cfg_bank_programmer_if #(
  parameter int BL_WIDTH  = 315,
  parameter int WL_WIDTH  = 4,
  parameter int DIN_WIDTH = 32
);
  logic                 start;
  logic [DIN_WIDTH-1:0] cfg_data;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [BL_WIDTH-1:0]  bl_out;
  logic [WL_WIDTH-1:0]  wl_out;
  logic                 busy;
  logic                 done;
`ifdef CFG_CHECKSUM_EN
  logic [DIN_WIDTH-1:0] checksum;

  modport master (
    output start, cfg_data, cfg_valid,
    input  cfg_ready, bl_out, wl_out, busy, done, checksum
  );
  modport slave (
    input  start, cfg_data, cfg_valid,
    output cfg_ready, bl_out, wl_out, busy, done, checksum
  );
`else
  modport master (
    output start, cfg_data, cfg_valid,
    input  cfg_ready, bl_out, wl_out, busy, done
  );
  modport slave (
    input  start, cfg_data, cfg_valid,
    output cfg_ready, bl_out, wl_out, busy, done
  );
`endif
endinterface

// File: rtl/cfg_bank_programmer.sv
// Memory-bank configuration writer: assembles one bit-line row from the bitstream,
// then strobes that row's word line. CFG_CHECKSUM_EN adds an XOR checksum output.
module cfg_bank_programmer #(
  parameter int BL_WIDTH        = 315,
  parameter int WL_WIDTH        = 4,
  parameter int DIN_WIDTH       = 32,
  parameter int WL_PULSE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cfg_bank_programmer_if.slave  bus
);

  localparam int WPR    = (BL_WIDTH + DIN_WIDTH - 1) / DIN_WIDTH;
  localparam int WORD_W = $clog2(WPR + 1);
  localparam int ROW_W  = $clog2(WL_WIDTH + 1);
  localparam int PCNT_W = $clog2(WL_PULSE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [WL_WIDTH-1:0] wl_q, wl_d;
  logic                done_q, done_d;
  logic                load_accept;
  logic [BL_WIDTH-1:0] bl_vec;

  assign load_accept = (state_q == S_LOAD) && bus.cfg_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      row_q   <= '0;
      pcnt_q  <= '0;
      wl_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      row_q   <= row_d;
      pcnt_q  <= pcnt_d;
      wl_q    <= wl_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    row_d   = row_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          row_d   = '0;
          word_d  = '0;
        end
      end
      S_LOAD: begin
        if (load_accept) begin
          word_d = word_q + 1'b1;
          if (word_q == WORD_W'(WPR - 1)) begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        pcnt_d  = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (pcnt_q == PCNT_W'(WL_PULSE_CYCLES - 1)) begin
          state_d = S_HOLD;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (row_q == ROW_W'(WL_WIDTH - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          row_d   = row_q + 1'b1;
          word_d  = '0;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Word-line strobe is decoded from next state so it is glitch-free out of a flop.
  for (genvar gi = 0; gi < WL_WIDTH; gi++) begin : g_wl
    assign wl_d[gi] = (state_d == S_PULSE) && (row_d == ROW_W'(gi));
  end

  // The top slice is narrower than a word when BL_WIDTH is not a multiple of DIN_WIDTH.
  for (genvar gi = 0; gi < WPR; gi++) begin : g_slice
    localparam int LO = gi * DIN_WIDTH;
    localparam int SW = ((BL_WIDTH - LO) < DIN_WIDTH) ? (BL_WIDTH - LO) : DIN_WIDTH;
    logic [SW-1:0] slice_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        slice_q <= '0;
      end else if (load_accept && (word_q == WORD_W'(gi))) begin
        slice_q <= bus.cfg_data[SW-1:0];
      end
    end

    assign bl_vec[LO +: SW] = slice_q;
  end

`ifdef CFG_CHECKSUM_EN
  logic [DIN_WIDTH-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      csum_q <= '0;
    end else if (load_accept) begin
      csum_q <= csum_q ^ bus.cfg_data;
    end
  end

  assign bus.checksum = csum_q;
`endif

  assign bus.cfg_ready = (state_q == S_LOAD);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.wl_out    = wl_q;
  assign bus.bl_out    = bl_vec;

endmodule
